// File: rtl/lcd12864_pkg.sv
// rtl/lcd12864_pkg.sv - shared types and constants for the LCD12864 command sequencer
// Contents: FSM state enums, ST7920 init command table, text row base addresses,
//           blank character code and a ms-to-clock conversion helper.
package lcd12864_pkg;

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_INIT,
      ST_IDLE,
      ST_ROW_ADDR,
      ST_CHAR
   } state_t;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_REQ,
      HS_REL
   } hs_state_t;

   localparam logic [7:0] SPACE = 8'h20;

   localparam int INIT_LEN = 5;
   // function set (twice), display on, clear, entry mode increment
   localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{8'h30, 8'h30, 8'h0C, 8'h01, 8'h06};

   // DDRAM start address of each text row; rows 2/3 continue rows 0/1 on the ST7920
   localparam logic [7:0] ROW_BASE [4] = '{8'h80, 8'h90, 8'h88, 8'h98};

   function automatic logic [31:0] ms_to_clk(input int ms, input int mhz);
      return 32'(ms * mhz * 1000);
   endfunction

endpackage

// File: rtl/lcd12864_hs.sv
// rtl/lcd12864_hs.sv - one-byte REQ/REL handshake towards the LCD drive, with ack timeout
// Ports: clk, rst (async, active high); start/data/rs request a byte transfer when idle;
//        done pulses one clk after the drive releases busy; err pulses on ack timeout;
//        send_en/send_data/send_rs/send_rw go to the drive, send_busy comes back from it.
import lcd12864_pkg::*;

module lcd12864_hs #(
   parameter int CLK_FRE        = 50,
   parameter int ACK_TIMEOUT_MS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   input  logic       rs,
   output logic       done,
   output logic       err,
   output logic       send_en,
   output logic [7:0] send_data,
   output logic       send_rs,
   output logic       send_rw,
   input  logic       send_busy
);

   localparam logic [31:0] ACK_CLKS = ms_to_clk(ACK_TIMEOUT_MS, CLK_FRE);

   hs_state_t   state, state_nx;
   logic        done_nx, err_nx;
   logic [31:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= HS_IDLE;
         done      <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
         send_data <= 8'h00;
         send_rs   <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= done_nx;
         err   <= err_nx;
         // counts clocks spent in REQ; saturates rather than wrapping
         if (state != HS_REQ)
            cnt <= '0;
         else if (cnt != '1)
            cnt <= cnt + 32'd1;
         // byte is frozen at REQ entry: the drive latches it a slow tick after accepting
         if (state == HS_IDLE && start) begin
            send_data <= data;
            send_rs   <= rs;
         end
      end
   end

   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      case (state)
         HS_IDLE: if (start) state_nx = HS_REQ;
         HS_REQ: begin
            if (send_busy)
               state_nx = HS_REL;
            else if (cnt >= ACK_CLKS - 32'd1) begin
               state_nx = HS_IDLE;
               err_nx   = 1'b1;
            end
         end
         HS_REL: begin
            if (!send_busy) begin
               state_nx = HS_IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = HS_IDLE;
      endcase
   end

   // decoded straight from the state register so reset drops it without waiting for a clock
   assign send_en = (state == HS_REQ);
   assign send_rw = 1'b0;

endmodule

// File: rtl/lcd12864_ctrl.sv
// rtl/lcd12864_ctrl.sv - LCD12864 init and text-screen refresh sequencer
// Ports: clk, rst (async, active high); wr_en/wr_addr/wr_data write the 64-char buffer;
//        refresh_req forces a redraw; init_done/refreshing/timeout_err report status;
//        send_en/send_data/send_rs/send_rw/send_busy form the byte handshake to the drive.
import lcd12864_pkg::*;

module lcd12864_ctrl #(
   parameter int CLK_FRE        = 50,
   parameter int PWR_MS         = 50,
   parameter int ACK_TIMEOUT_MS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [5:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       refresh_req,
   output logic       init_done,
   output logic       refreshing,
   output logic       timeout_err,
   output logic       send_en,
   output logic [7:0] send_data,
   output logic       send_rs,
   output logic       send_rw,
   input  logic       send_busy
);

   localparam logic [31:0] PWR_CLKS  = ms_to_clk(PWR_MS, CLK_FRE);
   localparam logic [2:0]  INIT_LAST = 3'(INIT_LEN - 1);

   state_t      state, state_nx;
   logic [31:0] ms_cnt;
   logic [2:0]  init_idx;
   logic [1:0]  row;
   logic [3:0]  col;
   logic        dirty;
   logic        in_flight;
   logic [7:0]  char_buf [64];

   logic        hs_start, hs_rs, hs_done, hs_err;
   logic [7:0]  hs_data;

   lcd12864_hs #(
      .CLK_FRE        (CLK_FRE),
      .ACK_TIMEOUT_MS (ACK_TIMEOUT_MS)
   ) u_hs (
      .clk       (clk),
      .rst       (rst),
      .start     (hs_start),
      .data      (hs_data),
      .rs        (hs_rs),
      .done      (hs_done),
      .err       (hs_err),
      .send_en   (send_en),
      .send_data (send_data),
      .send_rs   (send_rs),
      .send_rw   (send_rw),
      .send_busy (send_busy)
   );

   // in_flight blocks a new start until done/err has been consumed, which also
   // guarantees the idle gap between consecutive transactions
   always_comb begin
      state_nx = state;
      hs_start = 1'b0;
      hs_data  = 8'h00;
      hs_rs    = 1'b0;
      case (state)
         ST_PWR_WAIT: if (ms_cnt >= PWR_CLKS - 32'd1) state_nx = ST_INIT;
         ST_INIT: begin
            hs_start = !in_flight;
            hs_data  = INIT_CMDS[init_idx];
            if (hs_done && init_idx == INIT_LAST) state_nx = ST_IDLE;
         end
         ST_IDLE: if (dirty || refresh_req) state_nx = ST_ROW_ADDR;
         ST_ROW_ADDR: begin
            hs_start = !in_flight;
            hs_data  = ROW_BASE[row];
            if (hs_done) state_nx = ST_CHAR;
         end
         ST_CHAR: begin
            hs_start = !in_flight;
            hs_data  = char_buf[{row, col}];
            hs_rs    = 1'b1;
            if (hs_done && col == 4'd15)
               state_nx = (row == 2'd3) ? ST_IDLE : ST_ROW_ADDR;
         end
         default: state_nx = ST_PWR_WAIT;
      endcase
      if (hs_err) state_nx = ST_PWR_WAIT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_PWR_WAIT;
         ms_cnt      <= '0;
         init_idx    <= '0;
         row         <= '0;
         col         <= '0;
         dirty       <= 1'b1;
         in_flight   <= 1'b0;
         init_done   <= 1'b0;
         refreshing  <= 1'b0;
         timeout_err <= 1'b0;
         for (int i = 0; i < 64; i++) char_buf[i] <= SPACE;
      end else begin
         state <= state_nx;

         if (wr_en) char_buf[wr_addr] <= wr_data;

         if (hs_start)
            in_flight <= 1'b1;
         else if (hs_done || hs_err)
            in_flight <= 1'b0;

         if (state == ST_PWR_WAIT && state_nx == ST_PWR_WAIT) begin
            if (ms_cnt != '1) ms_cnt <= ms_cnt + 32'd1;
         end else begin
            ms_cnt <= '0;
         end

         case (state)
            ST_INIT: begin
               if (hs_done) begin
                  if (init_idx == INIT_LAST) begin
                     init_idx  <= '0;
                     init_done <= 1'b1;
                  end else begin
                     init_idx <= init_idx + 3'd1;
                  end
               end
            end
            ST_IDLE: begin
               if (dirty || refresh_req) begin
                  dirty      <= 1'b0;
                  refreshing <= 1'b1;
                  row        <= '0;
               end
            end
            ST_ROW_ADDR: if (hs_done) col <= '0;
            ST_CHAR: begin
               if (hs_done) begin
                  if (col == 4'd15) begin
                     col <= '0;
                     if (row == 2'd3)
                        refreshing <= 1'b0;
                     else
                        row <= row + 2'd1;
                  end else begin
                     col <= col + 4'd1;
                  end
               end
            end
            default: ;
         endcase

         // placed after the IDLE clear so a same-clk write or request keeps dirty set
         if (refresh_req && state != ST_IDLE) dirty <= 1'b1;
         if (wr_en) dirty <= 1'b1;

         // abandon the pass and rerun the whole power-up; the screen is redrawn afterwards
         if (hs_err) begin
            timeout_err <= 1'b1;
            init_done   <= 1'b0;
            refreshing  <= 1'b0;
            init_idx    <= '0;
            row         <= '0;
            col         <= '0;
            dirty       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lcd12864_ctrl.sv
// tb/tb_lcd12864_ctrl.sv - scoreboard bench for lcd12864_ctrl with a behavioural drive model
module tb_lcd12864_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [5:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       refresh_req = 1'b0;
   logic       send_busy = 1'b0;
   logic       init_done, refreshing, timeout_err, send_en, send_rs, send_rw;
   logic [7:0] send_data;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         req_cycle = 0;
   bit         dead = 1'b0;
   logic [8:0] exp_q [$];
   logic [7:0] mdl [64];

   lcd12864_ctrl #(
      .CLK_FRE        (1),
      .PWR_MS         (1),
      .ACK_TIMEOUT_MS (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .refresh_req (refresh_req),
      .init_done   (init_done),
      .refreshing  (refreshing),
      .timeout_err (timeout_err),
      .send_en     (send_en),
      .send_data   (send_data),
      .send_rs     (send_rs),
      .send_rw     (send_rw),
      .send_busy   (send_busy)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_init();
      logic [7:0] cmds [5] = '{8'h30, 8'h30, 8'h0C, 8'h01, 8'h06};
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, cmds[i]});
   endtask

   task automatic push_pass();
      logic [7:0] bases [4] = '{8'h80, 8'h90, 8'h88, 8'h98};
      for (int r = 0; r < 4; r++) begin
         exp_q.push_back({1'b0, bases[r]});
         for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, mdl[r*16 + c]});
      end
   endtask

   task automatic drain(input string name, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !refreshing && !send_en && !send_busy) break;
      end
      chk({name, "_drain_expired"}, (k == budget), 0);
      repeat (40) @(negedge clk);
      chk({name, "_leftover"}, exp_q.size(), 0);
   endtask

   task automatic pulse_refresh();
      @(negedge clk);
      refresh_req = 1'b1;
      @(negedge clk);
      refresh_req = 1'b0;
   endtask

   // drive model + monitor: busy rises 3 clk after send_en is seen, falls 5 clk later
   initial begin
      int         ph, n;
      logic [7:0] cd;
      logic       cr;
      bit         stable;
      logic [8:0] e;
      ph = 0;
      n  = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ph = 0;
            send_busy = 1'b0;
         end else begin
            case (ph)
               0: if (send_en) begin
                  cd = send_data;
                  cr = send_rs;
                  req_cycle = cyc;
                  stable = 1'b1;
                  n  = 0;
                  ph = 1;
                  if (!dead) begin
                     checks++;
                     if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL txn_unexpected actual=%0h required=none", {cr, cd});
                     end else begin
                        e = exp_q.pop_front();
                        if ({cr, cd} !== e) begin
                           errors++;
                           $display("FAIL txn actual=%0h required=%0h", {cr, cd}, e);
                        end
                     end
                  end
               end
               1: begin
                  if (!send_en) begin
                     if (!dead) chk("early_drop", 1, 0);
                     ph = 0;
                  end else begin
                     if (send_data !== cd || send_rs !== cr || send_rw !== 1'b0) stable = 1'b0;
                     n++;
                     if (n == 3 && !dead) begin
                        chk("req_stable", stable, 1);
                        send_busy = 1'b1;
                        n  = 0;
                        ph = 2;
                     end
                  end
               end
               default: begin
                  n++;
                  if (n == 5) begin
                     send_busy = 1'b0;
                     ph = 0;
                  end
               end
            endcase
         end
      end
   end

   initial begin
      int k;
      int t0;
      for (int i = 0; i < 64; i++) mdl[i] = 8'h20;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_init_done", init_done, 0);
      chk("rst_refreshing", refreshing, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_send_en", send_en, 0);
      chk("rst_send_data", send_data, 0);
      chk("rst_send_rs", send_rs, 0);
      chk("rst_send_rw", send_rw, 0);

      // power-up wait, init, first blank redraw
      push_init();
      push_pass();
      rst = 1'b0;
      t0 = cyc;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (send_en) break;
      end
      chk("pwr_wait_len_ok", (k < 3000) && (cyc - t0 >= 1000), 1);
      drain("init_pass", 4000);
      chk("init_done_high", init_done, 1);
      chk("refreshing_low", refreshing, 0);

      // single write while idle: 0x41 at row 2 col 1
      @(negedge clk);
      wr_addr = 6'h21; wr_data = 8'h41; wr_en = 1'b1;
      mdl[6'h21] = 8'h41;
      push_pass();
      @(negedge clk);
      wr_en = 1'b0;
      drain("write_21", 4000);

      // write to the last cell while row 0 is being sent: picked up now and redrawn again
      mdl[63] = 8'h5A;
      push_pass();
      push_pass();
      pulse_refresh();
      for (k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (exp_q.size() <= 2*68 - 3) break;
      end
      chk("row0_reached", (k < 2000), 1);
      wr_addr = 6'd63; wr_data = 8'h5A; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      drain("write_63_mid", 6000);

      // drive never acknowledges
      dead = 1'b1;
      pulse_refresh();
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (timeout_err) break;
      end
      chk("timeout_err_set", timeout_err, 1);
      chk("timeout_send_en", send_en, 0);
      chk("timeout_latency_ok", (cyc - req_cycle >= 1000) && (cyc - req_cycle <= 1002), 1);
      dead = 1'b0;
      push_init();
      push_pass();
      t0 = cyc;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (send_en) break;
      end
      chk("rerun_pwr_wait_ok", (k < 3000) && (cyc - t0 >= 999), 1);
      drain("rerun", 4000);
      chk("timeout_sticky", timeout_err, 1);
      chk("rerun_init_done", init_done, 1);

      // reset in the middle of a data byte
      push_pass();
      pulse_refresh();
      for (k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (send_en && send_rs) break;
      end
      chk("char_reached", (k < 2000), 1);
      rst = 1'b1;
      #1;
      chk("midrst_send_en", send_en, 0);
      chk("midrst_init_done", init_done, 0);
      chk("midrst_refreshing", refreshing, 0);
      chk("midrst_timeout_err", timeout_err, 0);
      exp_q.delete();
      for (int i = 0; i < 64; i++) mdl[i] = 8'h20;
      push_init();
      push_pass();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      drain("after_rst", 4000);
      chk("after_rst_init_done", init_done, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd12864_ctrl.md
Name: lcd12864_ctrl

Overview:
- Upstream command sequencer for the LCD12864 drive stage (the ST7920 byte-level bus driver with busy-flag polling).
- Runs the power-up init sequence, then refreshes the 4x16-character text screen from an internal 64-byte character buffer.
- Issues one byte at a time over the drive's send_en/send_busy handshake.
- A host writes characters into the buffer; the block schedules redraws automatically.

Parameters:
- CLK_FRE, 50, system clock in MHz.
- PWR_MS, 50, power-on wait in ms before the first command.
- ACK_TIMEOUT_MS, 20, max wait for send_busy to rise after send_en is asserted.

Ports:
- clk  in  1  system clock (same clock as the drive).
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  host buffer write strobe, one clk.
- wr_addr  in  6  character index: row = wr_addr[5:4], col = wr_addr[3:0].
- wr_data  in  8  ASCII code to store.
- refresh_req  in  1  one-clk pulse forcing a full redraw.
- init_done  out  1  high once the init sequence has completed.
- refreshing  out  1  high while a redraw pass is in progress.
- timeout_err  out  1  sticky; set on handshake timeout, cleared only by rst.
- send_en  out  1  request to the drive.
- send_data  out  8  byte to the drive.
- send_rs  out  1  0 = command, 1 = data.
- send_rw  out  1  always 0 (write).
- send_busy  in  1  drive busy; low while the drive is idle or polling the LCD busy flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - Buffer all 0x20 (space).
  - dirty = 1, so a redraw follows init.
  - FSM in PWR_WAIT; ms counter 0.
- Handshake, one transaction:
  - REQ: drive send_en = 1 and present data/rs/rw; hold all of them stable until send_busy is sampled high in clk.
    - Data must stay stable because the drive latches it a slow-clock tick after accepting, while send_busy is still low.
  - REL: drive send_en = 0, then wait for send_busy low. The transaction is complete on the first clk with send_busy = 0.
  - No new REQ may start in the same clk that REL completes; minimum 1 clk gap.
- Timeout:
  - If send_busy does not rise within ACK_TIMEOUT_MS * CLK_FRE * 1000 clk of REQ entry, set timeout_err, deassert send_en and return to PWR_WAIT.
  - This restarts the full init; buffer contents are kept.
- Main FSM:
  - PWR_WAIT: count PWR_MS * CLK_FRE * 1000 clk, then go to INIT.
  - INIT: send commands rs = 0 in order 0x30, 0x30, 0x0C, 0x01, 0x06, each via the handshake. After the last one, set init_done = 1 and go to IDLE.
  - IDLE: if dirty or refresh_req, clear dirty, set refreshing = 1, row = 0, go to ROW_ADDR.
  - ROW_ADDR: send command for the row start address: row 0 = 0x80, row 1 = 0x90, row 2 = 0x88, row 3 = 0x98. Then col = 0, go to CHAR.
  - CHAR: send data byte (rs = 1) = buf[{row, col}]; col++.
    - After col 15: if row == 3, refreshing = 0 and go to IDLE; else row++ and go to ROW_ADDR.
- Buffer writes:
  - Accepted every clk regardless of FSM state.
  - Each accepted write sets dirty.
  - A write during a pass takes effect if its cell has not been sent yet; dirty still forces one more full pass after the current one.
  - A write and the IDLE dirty-clear in the same clk: the write wins, dirty stays 1.
  - refresh_req while refreshing: latched into dirty.
- Data path: send_data is captured from the buffer at REQ entry and held through REQ, not combinationally re-read.
- Reset mid-transaction: send_en drops immediately (asynchronous); init restarts from PWR_WAIT. The drive is reset alongside, so no handshake recovery is needed.
- Counters: ms/timeout counters are 32-bit unsigned and saturate; row is 2 bits and col is 4 bits, with wrap handled explicitly by the FSM.

Decomposition:
- Package lcd12864_pkg:
  - FSM state enum.
  - INIT command constant array and its length (5).
  - Row base address constants.
  - SPACE = 8'h20.
- Sub-module lcd12864_hs: the REQ/REL handshake plus timeout counter.
  - Inputs: start, data, rs.
  - Outputs: done, err.
  - Drives the send_* ports.

Test Plan:
- Reset release with a drive model (busy high 3 clk after en, low 5 clk later) -> 5 commands 0x30, 0x30, 0x0C, 0x01, 0x06 with rs = 0 after PWR_MS; init_done rises; then 0x80 + 16 x 0x20, 0x90 + 16 x 0x20, 0x88 + ..., 0x98 + ...; refreshing falls.
- After idle, write addr 6'h21 = 0x41 -> one pass; 0x41 is sent as data byte index 1 following command 0x88.
- Write addr 63 = 0x5A while CHAR is on row 0 -> current pass sends 0x5A at the end of row 3; a second full pass follows.
- Drive model holding send_data changes check -> send_data/rs constant from REQ until send_busy rises in every transaction.
- Drive model never raises busy -> after ACK_TIMEOUT_MS, timeout_err = 1, send_en = 0, FSM reruns PWR_WAIT then INIT.
- Assert rst mid-CHAR -> send_en = 0 in the same cycle, init_done = 0; buffer reads 0x20 after release.
